// File: rtl/rob_commit.sv
// rob_commit: in-order retirement buffer in front of a dual-write-port register file.
// Entries are allocated in program order at the tail and completed out of order by two result
// buses. Up to two completed head entries retire per cycle.
//
// Ports
//   clk_i, rst_ni            clock (posedge), asynchronous active-low reset
//   flush_i                  synchronous discard of every entry
//   alloc_valid_i/_wen_i/_dest_i, alloc_ready_o, alloc_tag_o   dispatch interface
//   cdb{0,1}_valid_i/_tag_i/_data_i                          result buses (cdb0 wins on clash)
//   commit_we_o/_reg_o/_data_o, commit_we2_o/_reg2_o/_data2_o register file write ports
//   count_o, empty_o         occupancy
module rob_commit #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              alloc_valid_i,
    input  logic              alloc_wen_i,
    input  logic [4:0]        alloc_dest_i,
    output logic              alloc_ready_o,
    output logic [TAG_W-1:0]  alloc_tag_o,
    input  logic              cdb0_valid_i,
    input  logic [TAG_W-1:0]  cdb0_tag_i,
    input  logic [DATA_W-1:0] cdb0_data_i,
    input  logic              cdb1_valid_i,
    input  logic [TAG_W-1:0]  cdb1_tag_i,
    input  logic [DATA_W-1:0] cdb1_data_i,
    output logic              commit_we_o,
    output logic [4:0]        commit_reg_o,
    output logic [DATA_W-1:0] commit_data_o,
    output logic              commit_we2_o,
    output logic [4:0]        commit_reg2_o,
    output logic [DATA_W-1:0] commit_data2_o,
    output logic [TAG_W:0]    count_o,
    output logic              empty_o
);

    localparam logic [TAG_W:0] FullCnt = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  wen_q, wen_d;
    logic [4:0]        dest_q [DEPTH];
    logic [4:0]        dest_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic [TAG_W-1:0]  head1;
    logic              ret0, ret1;
    logic [1:0]        n_ret;
    logic              alloc_fire;
    logic              w0, w1;

    assign head1 = head_q + TAG_W'(1);
    assign ret0  = busy_q[head_q] & done_q[head_q];
    assign ret1  = ret0 & busy_q[head1] & done_q[head1];
    // ret1 implies ret0, so the retire count is {ret1, ret0 ^ ret1}
    assign n_ret = {ret1, ret0 ^ ret1};

    // Registered count only: entries retiring this cycle do not free space until next cycle.
    assign alloc_ready_o = (count_q < FullCnt) & ~flush_i;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;
    assign alloc_tag_o   = tail_q;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        wen_d   = wen_q;
        dest_d  = dest_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // cdb1 applied first so cdb0 overwrites it when both name the same entry
            if (cdb1_valid_i && busy_q[cdb1_tag_i] && !done_q[cdb1_tag_i]) begin
                done_d[cdb1_tag_i] = 1'b1;
                data_d[cdb1_tag_i] = cdb1_data_i;
            end
            if (cdb0_valid_i && busy_q[cdb0_tag_i] && !done_q[cdb0_tag_i]) begin
                done_d[cdb0_tag_i] = 1'b1;
                data_d[cdb0_tag_i] = cdb0_data_i;
            end
            if (ret0) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
            end
            if (ret1) begin
                busy_d[head1] = 1'b0;
                done_d[head1] = 1'b0;
            end
            // The tail entry is never busy when allocation is possible, so it cannot collide
            // with a retire or a completion above.
            if (alloc_fire) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                wen_d[tail_q]  = alloc_wen_i & (alloc_dest_i != 5'd0);
                dest_d[tail_q] = alloc_dest_i;
                tail_d         = tail_q + TAG_W'(1);
            end
            head_d  = head_q + TAG_W'(n_ret);
            count_d = count_q + (TAG_W + 1)'(alloc_fire) - (TAG_W + 1)'(n_ret);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            done_q  <= '0;
            wen_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is only observed while its entry is busy, so it needs no reset.
    always_ff @(posedge clk_i) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end

    // Oldest writing entry on port 1, younger on port 2; port 2 never used without port 1.
    always_comb begin
        w0             = ret0 & wen_q[head_q] & ~flush_i;
        w1             = ret1 & wen_q[head1] & ~flush_i;
        commit_we_o    = 1'b0;
        commit_reg_o   = '0;
        commit_data_o  = '0;
        commit_we2_o   = 1'b0;
        commit_reg2_o  = '0;
        commit_data2_o = '0;
        if (w0) begin
            commit_we_o   = 1'b1;
            commit_reg_o  = dest_q[head_q];
            commit_data_o = data_q[head_q];
            if (w1) begin
                commit_we2_o   = 1'b1;
                commit_reg2_o  = dest_q[head1];
                commit_data2_o = data_q[head1];
            end
        end else if (w1) begin
            commit_we_o   = 1'b1;
            commit_reg_o  = dest_q[head1];
            commit_data_o = data_q[head1];
        end
    end

endmodule
